regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
Access sequencer that drives a WIDTH-wide array of register-file bit slices from the initiator side.
- Accepts single read/write requests over a valid/ready interface.
- Generates the one-hot register select, the left/right write strobes and the write data.
- Samples the slices' registered outputs and returns a response.
- Sits between test/debug logic, or a microcode stub, and the register-file slice array.

Parameters:
WIDTH, 16, number of bit slices driven (data width)
HOLD_CYC, 1, eclk cycles select/strobe held per access (legal 1..4)

Ports:
eclk  input  1  emulation clock, all state on rising edge
erst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept request
req_write  input  1  1=write, 0=read
req_reg  input  4  register index 0..13 (0=pc, 1=ir, 2=wz, 3=sp, 4=iy, 5=ix, 6..13=hl1,hl0,de1,de0,bc1,bc0,af1,af0)
req_data  input  WIDTH  write data
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed
rsp_data  output  WIDTH  read data (writes: echo of written data)
rsp_err  output  1  bad index, or verify mismatch (see feature)
sel  output  14  one-hot register select to slices, bit i = register i
pc_wr  output  1  left-bus write strobe
reg_wr  output  1  right-bus write strobe
r_p  output  1  bus join; held 0 by this block
pc_din  output  WIDTH  left-bus write data
reg_din  output  WIDTH  right-bus write data
pc_dout  input  WIDTH  slice left output, inverted polarity
reg_dout  input  WIDTH  slice right output, true polarity

Behaviour:
- Async reset (erst_n=0) values: sel=0, pc_wr=0, reg_wr=0, r_p=0, pc_din=all-1, reg_din=all-1, rsp_valid=0, rsp_data=0, rsp_err=0, state=IDLE. req_ready=1 only in IDLE.
- Reset mid-operation aborts the access immediately and drops the request; no partial response.
- All outputs are registered.
- Bus side: index 0,1 = left (pc_wr/pc_din/pc_dout); 2..13 = right (reg_wr/reg_din/reg_dout).
- FSM states: IDLE, DRIVE, CAPTURE, RESP (plus VERIFY when the feature is compiled in).
- IDLE: handshake when req_valid & req_ready. Latch req_write, req_reg, req_data.
  - Index 14/15: go to RESP with rsp_err=1, rsp_data=0, no bus activity.
  - Otherwise go to DRIVE.
- DRIVE: held HOLD_CYC cycles (counter).
  - sel = one-hot(index).
  - Write: assert the side's strobe and put data on its din; the other din stays all-1.
  - Read: no strobe; both din stay all-1.
  - Exiting DRIVE clears sel, strobes and din to idle values the same edge.
- CAPTURE: one cycle, since slice outputs are registered one eclk after select.
  - Read: rsp_data = ~pc_dout (left) or reg_dout (right), sampled at end of CAPTURE.
  - Write: rsp_data = latched data.
  - Then go to RESP.
- RESP: rsp_valid=1; hold rsp_data/rsp_err stable until rsp_ready. On rsp_valid & rsp_ready go to IDLE.
  - req_ready rises the next cycle; there is no back-to-back acceptance in the same cycle as the response handshake.
- Latency, request handshake at edge t:
  - sel visible cycles t+1..t+HOLD_CYC.
  - rsp_valid first high in cycle t+HOLD_CYC+2.
- sel is never non-zero outside DRIVE/VERIFY. pc_wr and reg_wr are never both 1. r_p is constantly 0.
- Out-of-range HOLD_CYC (0 or >4) is a synthesis-time error.

Optional Feature:
Macro: REGFILE_ACCESS_VERIFY_EN.
- Defined: after a successful-index write, CAPTURE is followed by VERIFY.
  - VERIFY re-drives sel with no strobe for HOLD_CYC cycles, then spends one capture cycle.
  - The readback is compared with the written data; mismatch sets rsp_err=1, and rsp_data = readback value.
  - Write latency grows by HOLD_CYC+1 cycles. Reads are unchanged.
- Undefined: no VERIFY state. Writes respond with rsp_err=0 and echo data.

Test Plan:
- Reset check: hold erst_n=0 -> sel=0, strobes=0, din=16'hFFFF, rsp_valid=0, req_ready=1 after release.
- Write reg 3 (sp) data 16'hA55A, HOLD_CYC=1 -> sel=14'h0008 and reg_wr=1 for exactly one cycle with reg_din=16'hA55A, pc_din=16'hFFFF; rsp_valid at t+3, rsp_err=0.
- Read reg 0 (pc) with slice model returning pc_dout=16'h1234 -> rsp_data=16'hEDCB, pc_wr=0, reg_wr=0 throughout.
- Request reg 15 -> no sel/strobe activity, rsp_err=1, rsp_data=0.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0; release -> req_ready=1 next cycle.
- Assert erst_n=0 during DRIVE of a write to reg 13 -> strobe and sel drop asynchronously, no response emitted.
- With REGFILE_ACCESS_VERIFY_EN, slice model forces bit 0 stuck-0, write 16'h0001 -> rsp_err=1, rsp_data=16'h0000.

Source files
------------

// File: rtl/regfile_access_ctrl_if.sv
// Request/response bundle and register-file slice-bus bundle used by regfile_access_ctrl.
// Widths follow WIDTH, which must match the controller's WIDTH.
interface regfile_req_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [3:0]       req_reg;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req_valid, req_write, req_reg, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_reg, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

interface regfile_slice_if #(
  parameter int WIDTH = 16
);
  logic [13:0]      sel;
  logic             pc_wr;
  logic             reg_wr;
  logic             r_p;
  logic [WIDTH-1:0] pc_din;
  logic [WIDTH-1:0] reg_din;
  logic [WIDTH-1:0] pc_dout;
  logic [WIDTH-1:0] reg_dout;

  modport master (
    output sel, pc_wr, reg_wr, r_p, pc_din, reg_din,
    input  pc_dout, reg_dout
  );

  modport slave (
    input  sel, pc_wr, reg_wr, r_p, pc_din, reg_din,
    output pc_dout, reg_dout
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Single-access sequencer for a register-file slice array: one-hot select, left/right strobes, capture.
// Optional write read-back verify is compiled in with `define REGFILE_ACCESS_VERIFY_EN.
module regfile_access_ctrl #(
  parameter int WIDTH    = 16,
  parameter int HOLD_CYC = 1
) (
  input  logic             eclk,
  input  logic             erst_n,
  regfile_req_if.slave     req,
  regfile_slice_if.master  slc
);

  if (HOLD_CYC < 1 || HOLD_CYC > 4) begin : g_bad_hold_cyc
    $error("regfile_access_ctrl: HOLD_CYC must be in 1..4");
  end

  localparam logic [1:0]       LAST_CNT = 2'(HOLD_CYC - 1);
  localparam logic [WIDTH-1:0] DIN_IDLE = '1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_CAPTURE = 3'd2,
`ifdef REGFILE_ACCESS_VERIFY_EN
    ST_RESP    = 3'd3,
    ST_VERIFY  = 3'd4
`else
    ST_RESP    = 3'd3
`endif
  } state_t;

  state_t           r_state, w_state;
  logic [1:0]       r_cnt, w_cnt;
  logic             w_lat;

  logic             r_write;
  logic [3:0]       r_reg;
  logic [WIDTH-1:0] r_data;

  logic [13:0]      r_sel, w_sel;
  logic             r_pc_wr, w_pc_wr;
  logic             r_reg_wr, w_reg_wr;
  logic [WIDTH-1:0] r_pc_din, w_pc_din;
  logic [WIDTH-1:0] r_reg_din, w_reg_din;

  logic             r_req_ready, w_req_ready;
  logic             r_rsp_valid, w_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data, w_rsp_data;
  logic             r_rsp_err, w_rsp_err;

`ifdef REGFILE_ACCESS_VERIFY_EN
  logic             r_vfy, w_vfy;
  logic [13:0]      w_cur_sel;
  assign w_cur_sel = 14'd1 << r_reg;
`endif

  logic             w_req_bad;
  logic             w_req_left;
  logic [13:0]      w_req_sel;
  logic             w_cur_left;
  logic [WIDTH-1:0] w_rdback;

  assign w_req_bad  = (req.req_reg > 4'd13);
  assign w_req_left = (req.req_reg < 4'd2);
  assign w_req_sel  = 14'd1 << req.req_reg;
  assign w_cur_left = (r_reg < 4'd2);
  // Left slices present inverted data; normalise to true polarity here.
  assign w_rdback   = w_cur_left ? ~slc.pc_dout : slc.reg_dout;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_lat       = 1'b0;
    w_sel       = r_sel;
    w_pc_wr     = r_pc_wr;
    w_reg_wr    = r_reg_wr;
    w_pc_din    = r_pc_din;
    w_reg_din   = r_reg_din;
    w_req_ready = r_req_ready;
    w_rsp_valid = r_rsp_valid;
    w_rsp_data  = r_rsp_data;
    w_rsp_err   = r_rsp_err;
`ifdef REGFILE_ACCESS_VERIFY_EN
    w_vfy       = r_vfy;
`endif

    case (r_state)
      ST_IDLE: begin
        if (req.req_valid && r_req_ready) begin
          w_lat       = 1'b1;
          w_req_ready = 1'b0;
`ifdef REGFILE_ACCESS_VERIFY_EN
          w_vfy       = 1'b0;
`endif
          if (w_req_bad) begin
            w_state     = ST_RESP;
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
            w_rsp_data  = '0;
          end else begin
            w_state = ST_DRIVE;
            w_cnt   = '0;
            w_sel   = w_req_sel;
            if (req.req_write) begin
              if (w_req_left) begin
                w_pc_wr  = 1'b1;
                w_pc_din = req.req_data;
              end else begin
                w_reg_wr  = 1'b1;
                w_reg_din = req.req_data;
              end
            end
          end
        end
      end

      ST_DRIVE: begin
        if (r_cnt == LAST_CNT) begin
          w_state   = ST_CAPTURE;
          w_sel     = '0;
          w_pc_wr   = 1'b0;
          w_reg_wr  = 1'b0;
          w_pc_din  = DIN_IDLE;
          w_reg_din = DIN_IDLE;
        end else begin
          w_cnt = r_cnt + 2'd1;
        end
      end

      ST_CAPTURE: begin
        w_state     = ST_RESP;
        w_rsp_valid = 1'b1;
        w_rsp_err   = 1'b0;
        w_rsp_data  = r_write ? r_data : w_rdback;
`ifdef REGFILE_ACCESS_VERIFY_EN
        if (r_write && !r_vfy) begin
          w_state     = ST_VERIFY;
          w_rsp_valid = 1'b0;
          w_rsp_data  = r_rsp_data;
          w_cnt       = '0;
          w_sel       = w_cur_sel;
          w_vfy       = 1'b1;
        end else if (r_vfy) begin
          w_rsp_data = w_rdback;
          w_rsp_err  = (w_rdback != r_data);
        end
`endif
      end

`ifdef REGFILE_ACCESS_VERIFY_EN
      // Read-back pass: select only, strobes stay low.
      ST_VERIFY: begin
        if (r_cnt == LAST_CNT) begin
          w_state = ST_CAPTURE;
          w_sel   = '0;
        end else begin
          w_cnt = r_cnt + 2'd1;
        end
      end
`endif

      ST_RESP: begin
        if (req.rsp_ready) begin
          w_state     = ST_IDLE;
          w_rsp_valid = 1'b0;
          w_req_ready = 1'b1;
        end
      end

      default: begin
        w_state     = ST_IDLE;
        w_sel       = '0;
        w_pc_wr     = 1'b0;
        w_reg_wr    = 1'b0;
        w_pc_din    = DIN_IDLE;
        w_reg_din   = DIN_IDLE;
        w_rsp_valid = 1'b0;
        w_req_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge eclk or negedge erst_n) begin
    if (!erst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_reg       <= '0;
      r_data      <= '0;
      r_sel       <= '0;
      r_pc_wr     <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_pc_din    <= DIN_IDLE;
      r_reg_din   <= DIN_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
`ifdef REGFILE_ACCESS_VERIFY_EN
      r_vfy       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_sel       <= w_sel;
      r_pc_wr     <= w_pc_wr;
      r_reg_wr    <= w_reg_wr;
      r_pc_din    <= w_pc_din;
      r_reg_din   <= w_reg_din;
      r_req_ready <= w_req_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_data  <= w_rsp_data;
      r_rsp_err   <= w_rsp_err;
`ifdef REGFILE_ACCESS_VERIFY_EN
      r_vfy       <= w_vfy;
`endif
      if (w_lat) begin
        r_write <= req.req_write;
        r_reg   <= req.req_reg;
        r_data  <= req.req_data;
      end
    end
  end

  assign req.req_ready = r_req_ready;
  assign req.rsp_valid = r_rsp_valid;
  assign req.rsp_data  = r_rsp_data;
  assign req.rsp_err   = r_rsp_err;

  assign slc.sel     = r_sel;
  assign slc.pc_wr   = r_pc_wr;
  assign slc.reg_wr  = r_reg_wr;
  assign slc.r_p     = 1'b0;
  assign slc.pc_din  = r_pc_din;
  assign slc.reg_din = r_reg_din;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl: expected responses queued at issue, checked by a response monitor.
// Slice array is a behavioural model with registered outputs and bit 0 of register 5 stuck at 0.
module tb_regfile_access_ctrl;
  localparam int W    = 16;
  localparam int HOLD = 1;
  localparam logic [W-1:0] STUCK_MASK = 16'hFFFE;

  logic eclk   = 1'b0;
  logic erst_n = 1'b0;

  regfile_req_if   #(.WIDTH(W)) req_if ();
  regfile_slice_if #(.WIDTH(W)) slc_if ();

  regfile_access_ctrl #(.WIDTH(W), .HOLD_CYC(HOLD)) dut (
    .eclk   (eclk),
    .erst_n (erst_n),
    .req    (req_if),
    .slc    (slc_if)
  );

  always #5 eclk = ~eclk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  logic excl_bad  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural slice array: writes on strobe, outputs registered one eclk after select.
  logic [W-1:0] slice_mem [14];
  always @(posedge eclk) begin
    for (int i = 0; i < 14; i++) begin
      if (slc_if.sel[i]) begin
        if (i < 2) begin
          if (slc_if.pc_wr) slice_mem[i] <= slc_if.pc_din;
          slc_if.pc_dout <= ~slice_mem[i];
        end else begin
          if (slc_if.reg_wr) slice_mem[i] <= (i == 5) ? (slc_if.reg_din & STUCK_MASK) : slc_if.reg_din;
          slc_if.reg_dout <= slice_mem[i];
        end
      end
    end
  end

  // Response monitor and bus-invariant watch.
  always @(negedge eclk) begin
    exp_t e;
    if (slc_if.pc_wr === 1'b1 && slc_if.reg_wr === 1'b1) excl_bad = 1'b1;
    if (slc_if.r_p !== 1'b0) excl_bad = 1'b1;
    if (erst_n && req_if.rsp_valid && req_if.rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", 32'(req_if.rsp_data), 32'(e.data));
        chk("rsp_err", 32'(req_if.rsp_err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge eclk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [3:0] idx, input logic [W-1:0] dat,
                      input logic [W-1:0] e_dat, input logic e_err, input logic push);
    int   n = 0;
    exp_t e;
    while (req_if.req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 32'(req_if.req_ready), 32'd1);
    if (push) begin
      e.data = e_dat;
      e.err  = e_err;
      exp_q.push_back(e);
    end
    req_if.req_valid = 1'b1;
    req_if.req_write = wr;
    req_if.req_reg   = idx;
    req_if.req_data  = dat;
    tick();
    req_if.req_valid = 1'b0;
    req_if.req_write = 1'b0;
    req_if.req_reg   = 4'd0;
    req_if.req_data  = '0;
  endtask

  task automatic wait_done(input string name, output logic strobe_seen, output logic sel_seen);
    int n = 0;
    strobe_seen = 1'b0;
    sel_seen    = 1'b0;
    while ((exp_q.size() != 0 || req_if.req_ready !== 1'b1) && n < 60) begin
      strobe_seen = strobe_seen | slc_if.pc_wr | slc_if.reg_wr;
      sel_seen    = sel_seen | (slc_if.sel != 14'd0);
      tick();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         stb, sl, stable, seen_v;
    logic [W-1:0] hold;
    int           n;

    req_if.req_valid = 1'b0;
    req_if.req_write = 1'b0;
    req_if.req_reg   = 4'd0;
    req_if.req_data  = '0;
    req_if.rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge eclk);
    #1;
    chk("rst_sel", 32'(slc_if.sel), 32'd0);
    chk("rst_strobes", 32'({slc_if.pc_wr, slc_if.reg_wr}), 32'd0);
    chk("rst_din", {slc_if.pc_din, slc_if.reg_din}, 32'hFFFF_FFFF);
    chk("rst_rsp_valid", 32'(req_if.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'({req_if.rsp_err, req_if.rsp_data}), 32'd0);
    erst_n = 1'b1;
    tick();
    chk("rst_req_ready", 32'(req_if.req_ready), 32'd1);

    // Write sp (reg 3), cycle-by-cycle timing
    send(1'b1, 4'd3, 16'hA55A, 16'hA55A, 1'b0, 1'b1);
    chk("wr3_sel", 32'(slc_if.sel), 32'h0008);
    chk("wr3_strobes", 32'({slc_if.pc_wr, slc_if.reg_wr}), 32'b01);
    chk("wr3_din", {slc_if.pc_din, slc_if.reg_din}, 32'hFFFF_A55A);
    chk("wr3_req_ready_busy", 32'(req_if.req_ready), 32'd0);
    tick();
    chk("wr3_sel_off", 32'(slc_if.sel), 32'd0);
    chk("wr3_strobes_off", 32'({slc_if.pc_wr, slc_if.reg_wr}), 32'd0);
    chk("wr3_din_idle", {slc_if.pc_din, slc_if.reg_din}, 32'hFFFF_FFFF);
    chk("wr3_no_rsp_t2", 32'(req_if.rsp_valid), 32'd0);
    tick();
`ifdef REGFILE_ACCESS_VERIFY_EN
    chk("wr3_vfy_sel", 32'(slc_if.sel), 32'h0008);
    chk("wr3_vfy_strobes", 32'({slc_if.pc_wr, slc_if.reg_wr}), 32'd0);
    chk("wr3_vfy_no_rsp", 32'(req_if.rsp_valid), 32'd0);
`else
    chk("wr3_rsp_t3", 32'(req_if.rsp_valid), 32'd1);
`endif
    wait_done("wr3_done", stb, sl);

    // Write pc (reg 0), left bus
    send(1'b1, 4'd0, 16'hEDCB, 16'hEDCB, 1'b0, 1'b1);
    chk("wr0_sel", 32'(slc_if.sel), 32'h0001);
    chk("wr0_strobes", 32'({slc_if.pc_wr, slc_if.reg_wr}), 32'b10);
    chk("wr0_din", {slc_if.pc_din, slc_if.reg_din}, 32'hEDCB_FFFF);
    wait_done("wr0_done", stb, sl);

    send(1'b1, 4'd13, 16'h5A5A, 16'h5A5A, 1'b0, 1'b1);
    wait_done("wr13_done", stb, sl);
    send(1'b1, 4'd1, 16'h8001, 16'h8001, 1'b0, 1'b1);
    wait_done("wr1_done", stb, sl);

    // Read pc: slice returns inverted 0x1234
    send(1'b0, 4'd0, 16'h0000, 16'hEDCB, 1'b0, 1'b1);
    chk("rd0_sel", 32'(slc_if.sel), 32'h0001);
    chk("rd0_din", {slc_if.pc_din, slc_if.reg_din}, 32'hFFFF_FFFF);
    wait_done("rd0_done", stb, sl);
    chk("rd0_no_strobe", 32'(stb), 32'd0);

    send(1'b0, 4'd1, 16'h0000, 16'h8001, 1'b0, 1'b1);
    wait_done("rd1_done", stb, sl);

    // Bad indices: error response, bus stays quiet
    send(1'b1, 4'd15, 16'h1234, 16'h0000, 1'b1, 1'b1);
    wait_done("bad15_done", stb, sl);
    chk("bad15_bus_quiet", 32'({stb, sl}), 32'd0);
    send(1'b0, 4'd14, 16'h0000, 16'h0000, 1'b1, 1'b1);
    wait_done("bad14_done", stb, sl);
    chk("bad14_bus_quiet", 32'({stb, sl}), 32'd0);

    // Response backpressure
    req_if.rsp_ready = 1'b0;
    send(1'b0, 4'd3, 16'h0000, 16'hA55A, 1'b0, 1'b1);
    n = 0;
    while (req_if.rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("bp_valid_seen", 32'(req_if.rsp_valid), 32'd1);
    hold   = req_if.rsp_data;
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (req_if.rsp_valid !== 1'b1 || req_if.rsp_data !== hold || req_if.req_ready !== 1'b0)
        stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    req_if.rsp_ready = 1'b1;
    tick();
    chk("bp_req_ready_next", 32'(req_if.req_ready), 32'd1);
    chk("bp_rsp_valid_low", 32'(req_if.rsp_valid), 32'd0);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset during DRIVE of a write to reg 13
    send(1'b1, 4'd13, 16'h1111, 16'h0000, 1'b0, 1'b0);
    chk("abort_sel_before", 32'(slc_if.sel), 32'h2000);
    chk("abort_wr_before", 32'(slc_if.reg_wr), 32'd1);
    #2;
    erst_n = 1'b0;
    #1;
    chk("abort_sel", 32'(slc_if.sel), 32'd0);
    chk("abort_strobes", 32'({slc_if.pc_wr, slc_if.reg_wr}), 32'd0);
    chk("abort_din", {slc_if.pc_din, slc_if.reg_din}, 32'hFFFF_FFFF);
    repeat (2) @(posedge eclk);
    #1;
    erst_n = 1'b1;
    seen_v = 1'b0;
    repeat (10) begin
      seen_v = seen_v | req_if.rsp_valid;
      tick();
    end
    chk("abort_no_rsp", 32'(seen_v), 32'd0);
    chk("abort_req_ready", 32'(req_if.req_ready), 32'd1);
    send(1'b0, 4'd13, 16'h0000, 16'h5A5A, 1'b0, 1'b1);
    wait_done("rd13_done", stb, sl);

    // Stuck-at-0 bit 0 on reg 5 (ix)
`ifdef REGFILE_ACCESS_VERIFY_EN
    send(1'b1, 4'd5, 16'h0001, 16'h0000, 1'b1, 1'b1);
`else
    send(1'b1, 4'd5, 16'h0001, 16'h0001, 1'b0, 1'b1);
`endif
    wait_done("wr5_done", stb, sl);
    send(1'b0, 4'd5, 16'h0000, 16'h0000, 1'b0, 1'b1);
    wait_done("rd5_done", stb, sl);

    chk("excl_strobe_rp", 32'(excl_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
